// File: rtl/avalon_wait_mem.sv
// avalon_wait_mem: Avalon-MM slave memory with programmable wait states,
// byte-enabled writes and a 16-bit completed-transfer counter.
// Optional build macro AVMEM_RANDOM_WAIT_EN adds 0..3 pseudo-random extra
// wait states per request, drawn from an 8-bit LFSR.
module avalon_wait_mem #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Read,
  input  logic                Write,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   ReadData,
  output logic                Waitreq,
  output logic [15:0]         XferCount
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 4) + 1;
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT              state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext, tgt;
  logic [ADDR_W-1:0]  addrQ;
  logic               rdQ, wrQ;
  logic               req, accept, changed, inRange;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign req     = Read | Write;
  assign inRange = {1'b0, Addr} < DEPTH_X;
  assign idx     = Addr[IDX_W-1:0];
  // Address or command moved while stalled: the new request restarts its wait.
  assign changed = (state == WAIT) && ((Addr != addrQ) || (Read != rdQ) || (Write != wrQ));
  assign Waitreq = req && (cnt != tgt);
  // tgt >= 1 and cnt is 0 in IDLE, so accept can only happen from WAIT.
  assign accept  = req && (cnt == tgt);

`ifdef AVMEM_RANDOM_WAIT_EN
  logic [7:0]       lfsr;
  logic [CNT_W-1:0] tgtQ;
  logic             fb;

  // x^8+x^6+x^5+x^4+1, shifted toward the MSB
  assign fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign tgt = tgtQ;

  // LFSR steps per completed transfer; target latched as a request leaves IDLE
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr <= 8'hA5;
      tgtQ <= CNT_W'(WAIT_CYCLES);
    end else begin
      if (accept) lfsr <= {lfsr[6:0], fb};
      if (state == IDLE && req) tgtQ <= CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr[1:0]);
    end
  end
`else
  assign tgt = CNT_W'(WAIT_CYCLES);
`endif

  // State, wait counter, and last-seen request for change detection
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= '0;
      addrQ <= '0;
      rdQ   <= 1'b0;
      wrQ   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      addrQ <= Addr;
      rdQ   <= Read;
      wrQ   <= Write;
    end
  end

  // Next state: count up while stalled, clear on accept, abort or restart
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (req) begin
        stateNext = WAIT;
        cntNext   = cnt + CNT_W'(1);
      end
      WAIT: begin
        if (!req || accept) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (changed) begin
          cntNext = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Read register follows mem[Addr] on every read edge; a write collision holds it
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)              ReadData <= '0;
    else if (Read && !Write)  ReadData <= inRange ? mem[idx] : '0;
  end

  // Completed-transfer counter, wraps naturally at 16 bits
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)     XferCount <= '0;
    else if (accept) XferCount <= XferCount + 16'd1;
  end

  // Byte-lane writes on the accept edge; out-of-range writes are dropped
  always_ff @(posedge Clock) begin
    if (accept && Write && inRange) begin
      for (int b = 0; b < NB; b++) begin
        if (ByteEn[b]) mem[idx][b*8 +: 8] <= WriteData[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/avalon_wait_mem.md
# avalon_wait_mem

Parametrised Avalon-MM slave memory with programmable wait states, byte enables and a completed-transfer counter. It is the successor to the fixed 16-bit data bus model that sits between the pipelined processor's data port and memory. It drives `Waitreq` so the processor's stall path can be exercised at any width, depth and latency.

## Interface
Parameters:
- `DATA_W`, default 16: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 12: word address width.
- `DEPTH`, default 4096: number of words; must be ≤ 2^ADDR_W.
- `WAIT_CYCLES`, default 2: base wait states; must be ≥ 1.

Ports:
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Read` in 1: read request.
- `Write` in 1: write request.
- `Addr` in ADDR_W: word address.
- `WriteData` in DATA_W: write data.
- `ByteEn` in DATA_W/8: byte lanes to write; ignored for reads.
- `ReadData` out DATA_W: read data; valid in the cycle `Waitreq` is low with `Read` high.
- `Waitreq` out 1: slave stall, combinational from state and inputs.
- `XferCount` out 16: count of completed transfers; wraps at 0xFFFF→0.

## Operation
- A request is `Read | Write`. The master holds `Addr`, `WriteData`, `ByteEn` and the command stable until `Waitreq` is low.
- Wait counter `cnt` has width clog2(WAIT_CYCLES+4)+1. Per-request target is `tgt`: WAIT_CYCLES, plus the random term under the macro.
- `Waitreq = req && (cnt != tgt)`.
- States:
  - IDLE: no request.
  - WAIT: request seen, `cnt < tgt`.
  - Accept is not a separate state: it is the cycle in which `cnt == tgt`.
- Transitions:
  - IDLE→WAIT when a request is present; `cnt` increments every cycle while in WAIT.
  - On the accept edge, the transfer completes, `cnt` returns to 0 and the FSM returns to IDLE. A back-to-back request starts a fresh count on the next cycle.
- Read: `ReadData` is a register loaded with `mem[Addr]` on every edge where `Read` is high, so it is valid from request cycle 2 onward.
- Write: on the accept edge, each byte lane i with `ByteEn[i]=1` is written to `mem[Addr]`. Other lanes are unchanged.
- Read and Write both high: Write wins. `ReadData` holds its prior value and one transfer is counted.
- Request deasserted during WAIT (abort): `cnt` clears to 0, there is no memory effect, and `XferCount` is unchanged.
- `Addr` or command changes during WAIT: the count restarts at 0 on the next edge. The new request must serve its full wait.
- `Addr ≥ DEPTH`: reads return 0; writes are dropped; the transfer still completes and is counted.
- `XferCount` increments by 1 on each accept edge.

## Timing
- Reset values (async, while `Resetn=0`):
  - FSM=IDLE, `cnt=0`, `ReadData=0`, `XferCount=0`.
  - `Waitreq` is low when no request is present.
  - Memory contents are not reset.
- Latency: a request first presented in cycle 1 sees `Waitreq=1` in cycles 1..tgt and `Waitreq=0` in cycle tgt+1, then completes at the end of cycle tgt+1. Total occupancy is tgt+1 cycles per transfer.
- Throughput: one transfer per tgt+1 cycles; there is no pipelining of outstanding requests.
- Reset asserted mid-transfer: the transfer is abandoned and no write occurs. After release, a held request restarts with a full wait.

## Configuration
- `AVMEM_RANDOM_WAIT_EN`
  - Defined:
    - An 8-bit LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset, advances once per accept edge.
    - For each request, `tgt = WAIT_CYCLES + lfsr[1:0]`, latched when leaving IDLE, so waits range over WAIT_CYCLES..WAIT_CYCLES+3.
  - Undefined: `tgt = WAIT_CYCLES` always; no LFSR logic is built.

## Test plan
- Reset then idle: `Resetn` low for 2 cycles → `ReadData=0`, `XferCount=0`, `Waitreq=0`.
- Fixed-wait write then read, WAIT_CYCLES=2, DATA_W=16:
  - Write 0xBEEF to addr 0x010, `ByteEn`=2'b11 → `Waitreq` high for 2 cycles, low in cycle 3.
  - Read addr 0x010 → `ReadData=0xBEEF` in its cycle 3; `XferCount=2`.
- Byte enables: memory holds 0xBEEF at 0x010; write 0x1234 with `ByteEn`=2'b01 → a subsequent read returns 0xBE34.
- Abort and restart: assert `Read` to 0x020 for 1 cycle, drop it, then reassert → the full 2-cycle wait is served again and `XferCount` increments only once.
- Out of range and collision, DEPTH=8:
  - Write to addr 9 → counted, and a read of addr 1 is unchanged.
  - `Read`+`Write` together to addr 3 with data 0x00AA → addr 3 becomes 0x00AA and `ReadData` is unchanged that cycle.
- With `AVMEM_RANDOM_WAIT_EN`: 1000 back-to-back reads → every wait lies within 2..5, all 4 wait values appear, and `XferCount=1000`.
